// File: rtl/up_counter_pkg.sv
// Shared constants and helpers for the up_counter block and its users.
package up_counter_pkg;

    localparam int COUNTER_WIDTH = 3;

    // All-ones value of a counter w bits wide; the natural wrap point.
    function automatic int default_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/up_counter_if.sv
// Control and status bundle between a counter and whoever drives it.
interface up_counter_if
    import up_counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;

    modport master (
        output en, load, load_val,
        input  q, tc, wrap
    );

    modport slave (
        input  en, load, load_val,
        output q, tc, wrap
    );
endinterface

// File: rtl/up_counter.sv
// Synchronous binary up-counter with saturating parallel load, terminal count
// and a one-cycle wrap pulse.
module up_counter
    import up_counter_pkg::*;
#(
    parameter int WIDTH   = COUNTER_WIDTH,
    parameter int MAX_VAL = default_max(WIDTH)
) (
    input  logic        clk,
    input  logic        reset,
    up_counter_if.slave cnt
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

    // Clamp loads so the count can never sit above the wrap point.
    function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
        return (v > MAX_Q) ? MAX_Q : v;
    endfunction

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (cnt.load) begin
            count_d = sat_load(cnt.load_val);
        end else if (cnt.en) begin
            if (count_q == MAX_Q) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign cnt.q    = count_q;
    assign cnt.wrap = wrap_q;
    assign cnt.tc   = (count_q == MAX_Q);

endmodule

// File: tb/tb_up_counter.sv
// Table-driven, scoreboarded bench for up_counter in three configurations:
// full 3-bit range, MAX_VAL=4 and the degenerate MAX_VAL=0.
module tb_up_counter;
    import up_counter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;

    up_counter_if #(.WIDTH(3)) if0 ();
    up_counter_if #(.WIDTH(3)) if1 ();
    up_counter_if #(.WIDTH(3)) if2 ();

    up_counter #(.WIDTH(3))              dut0 (.clk(clk), .reset(rst0), .cnt(if0));
    up_counter #(.WIDTH(3), .MAX_VAL(4)) dut1 (.clk(clk), .reset(rst1), .cnt(if1));
    up_counter #(.WIDTH(3), .MAX_VAL(0)) dut2 (.clk(clk), .reset(rst2), .cnt(if2));

    typedef struct {
        int dut;
        int rst;
        int en;
        int ld;
        int lv;
        int eq;
        int etc;
        int ew;
    } vec_t;

    typedef struct {
        int    dut;
        int    q;
        int    tc;
        int    w;
        string tag;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic drive(input int d, input int r, input int e, input int l, input int v);
        case (d)
            0: begin rst0 = (r != 0); if0.en = (e != 0); if0.load = (l != 0); if0.load_val = 3'(v); end
            1: begin rst1 = (r != 0); if1.en = (e != 0); if1.load = (l != 0); if1.load_val = 3'(v); end
            default: begin rst2 = (r != 0); if2.en = (e != 0); if2.load = (l != 0); if2.load_val = 3'(v); end
        endcase
    endtask

    task automatic check_head();
        exp_t x;
        int aq, atc, aw;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            return;
        end
        x = sb.pop_front();
        case (x.dut)
            0: begin aq = int'(if0.q); atc = int'(if0.tc); aw = int'(if0.wrap); end
            1: begin aq = int'(if1.q); atc = int'(if1.tc); aw = int'(if1.wrap); end
            default: begin aq = int'(if2.q); atc = int'(if2.tc); aw = int'(if2.wrap); end
        endcase
        check({x.tag, ".q"},    aq,  x.q);
        check({x.tag, ".tc"},   atc, x.tc);
        check({x.tag, ".wrap"}, aw,  x.w);
    endtask

    // Drive one vector away from the edge, then compare just after the edge.
    task automatic step(input vec_t v, input string tag);
        exp_t x;
        @(negedge clk);
        drive(v.dut, v.rst, v.en, v.ld, v.lv);
        x.dut = v.dut; x.q = v.eq; x.tc = v.etc; x.w = v.ew; x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        check_head();
    endtask

    initial begin
        vec_t v;
        int   k;

        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        if0.en = 1'b0; if0.load = 1'b0; if0.load_val = '0;
        if1.en = 1'b0; if1.load = 1'b0; if1.load_val = '0;
        if2.en = 1'b0; if2.load = 1'b0; if2.load_val = '0;

        // dut, rst, en, ld, lv, q, tc, wrap
        tbl.push_back('{0, 0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 2, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 3, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 4, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 5, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 6, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 7, 1, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 0, 0, 1});
        tbl.push_back('{0, 1, 1, 0, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 5, 5, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 6, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 6, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 6, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 6, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 7, 1, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 0, 0, 1});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 2, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 3, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 4, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 3, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 7, 7, 1, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 0, 0, 1});
        tbl.push_back('{0, 1, 1, 1, 2, 2, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 7, 7, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0});
        // MAX_VAL = 4
        tbl.push_back('{1, 0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 1, 7, 4, 1, 0});
        tbl.push_back('{1, 1, 1, 0, 0, 0, 0, 1});
        tbl.push_back('{1, 1, 1, 0, 0, 1, 0, 0});
        tbl.push_back('{1, 1, 1, 0, 0, 2, 0, 0});
        tbl.push_back('{1, 1, 1, 0, 0, 3, 0, 0});
        tbl.push_back('{1, 1, 1, 0, 0, 4, 1, 0});
        tbl.push_back('{1, 1, 1, 0, 0, 0, 0, 1});
        tbl.push_back('{1, 1, 0, 1, 4, 4, 1, 0});
        tbl.push_back('{1, 1, 1, 1, 5, 4, 1, 0});
        tbl.push_back('{1, 1, 1, 0, 0, 0, 0, 1});
        tbl.push_back('{1, 1, 0, 1, 3, 3, 0, 0});
        // MAX_VAL = 0
        tbl.push_back('{2, 0, 1, 0, 0, 0, 1, 0});
        tbl.push_back('{2, 1, 1, 0, 0, 0, 1, 1});
        tbl.push_back('{2, 1, 1, 0, 0, 0, 1, 1});
        tbl.push_back('{2, 1, 0, 0, 0, 0, 1, 0});
        tbl.push_back('{2, 1, 1, 1, 5, 0, 1, 0});
        tbl.push_back('{2, 1, 1, 0, 0, 0, 1, 1});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Long free run on the full-range counter: two complete wraps and more.
        v = '{0, 0, 1, 0, 0, 0, 0, 0};
        step(v, "run_rst");
        k = 0;
        for (int i = 0; i < 20; i++) begin
            k = (k == 7) ? 0 : k + 1;
            v = '{0, 1, 1, 0, 0, k, (k == 7) ? 1 : 0, (k == 0) ? 1 : 0};
            step(v, $sformatf("run%0d", i));
        end

        // Reset held several edges with en and load active keeps q at 0.
        v = '{1, 1, 0, 1, 2, 2, 0, 0};
        step(v, "hold_rst_ld");
        for (int i = 0; i < 3; i++) begin
            v = '{1, 0, 1, 1, 3, 0, 0, 0};
            step(v, $sformatf("hold_rst%0d", i));
        end
        v = '{1, 1, 1, 0, 0, 1, 0, 0};
        step(v, "after_rst");
        v = '{1, 1, 1, 0, 0, 2, 0, 0};
        step(v, "after_rst2");

        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/up_counter.md
Name: up_counter

Overview:
- Parameterised synchronous binary up-counter; the default configuration is the 3-bit counter the design calls up_counter_3bit.
- Counts on every enabled rising clock edge and wraps from MAX_VAL back to 0.
- Provides a synchronous parallel load, a terminal-count flag and a one-cycle wrap pulse.
- Used as a free-running sequence and cycle counter in the datapath test environment.

Parameters:
- WIDTH, 3, counter width in bits; must be ≥ 1.
- MAX_VAL, 2**WIDTH-1, highest count value before wrap to 0; legal range 0..2**WIDTH-1.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- en  input  1  count enable; tie to 1 for a free-running counter.
- load  input  1  synchronous parallel-load strobe; tie to 0 if unused.
- load_val  input  WIDTH  value loaded when load=1.
- q  output  WIDTH  current count, registered.
- tc  output  1  combinational terminal count: 1 when q == MAX_VAL.
- wrap  output  1  registered pulse: 1 for exactly the cycle after q wrapped MAX_VAL→0.

Behaviour:
- All state updates occur on the rising edge of clk; there is no asynchronous path.
- Priority at each edge: reset (low) > load > en > hold.
- Reset:
  - When reset=0 at an edge: q←0 and wrap←0, whatever en and load are.
  - tc then follows q, so it is 1 only when MAX_VAL=0.
- Load:
  - When load=1 and reset=1: q←load_val and wrap←0.
  - If load_val > MAX_VAL, q←MAX_VAL (saturate), so q never exceeds MAX_VAL.
- Enable:
  - When en=1, load=0 and reset=1: if q==MAX_VAL then q←0 and wrap←1; otherwise q←q+1 and wrap←0.
  - Arithmetic is modulo WIDTH bits; there is no carry-out port.
- Hold: with en=0, load=0 and reset=1, q holds and wrap←0.
- Latency:
  - q reflects the reset, load or increment one edge after the inputs are sampled.
  - tc is combinational from q, so it has zero added latency.
- Reset mid-count: asserting reset on any edge forces q=0 on that edge; counting resumes from 1 on the first enabled edge after reset is released.
- Power-up: q is undefined until the first edge with reset=0; the environment must apply reset for at least one clock.
- Degenerate MAX_VAL=0: q is stuck at 0, tc=1 constantly, and wrap=1 on every enabled edge.
- Simultaneous load=1 and en=1: the load wins and no increment occurs that cycle.

Decomposition:
- Shared package holds the default COUNTER_WIDTH=3 constant and a function computing the default MAX_VAL from a width.
- No sub-modules are required; implement as a single flat module with one clocked process for q/wrap and a continuous assignment for tc.
- Optional: provide a thin wrapper named up_counter_3bit with ports clk, reset and q that ties en=1 and load=0, for existing instantiations.

Test Plan:
- Reset: hold reset=0 for 1 cycle with en=1 → q=0, tc=0, wrap=0 after the edge; release reset → q=1,2,3 on successive edges.
- Free-run wrap (WIDTH=3): en=1 for 9 edges after reset → q=1,2,3,4,5,6,7,0,1; tc=1 only while q=7; wrap=1 only in the cycle q=0.
- Load priority: load=1, load_val=5, en=1 → q=5 next cycle (no increment); then en=1 → q=6.
- Mid-count reset: counting at q=4, drive reset=0 for one edge with en=1 and load=1 → q=0 and wrap=0; then q=1 on the next enabled edge.
- Hold: en=0 for 3 edges at q=6 → q stays 6, tc=0, wrap=0; re-enable → q=7 (tc=1), then q=0 (wrap=1).
- MAX_VAL=4, WIDTH=3: load_val=7 → q=4 (saturated); en=1 → q=0 with wrap=1; sequence 0,1,2,3,4,0 repeats.
